// File: rtl/cmul_narrow.sv
// cmul_narrow
// Joins the real and imaginary 36-bit product streams of the complex
// multiplier and reduces each lane to an 18-bit sample using round-half-up,
// an arithmetic right shift by SHIFT, and saturation to [-131072, 131071].
// Results pass through a DEPTH-entry FIFO and leave as packed {im, re}.
//
// Parameters
//   SHIFT   right-shift amount, legal 1..18
//   DEPTH   FIFO entries, power of two, >= 2
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   t0_dat/req/ack  real product input (req/ack handshake)
//   t1_dat/req/ack  imaginary product input (req/ack handshake)
//   i2_dat/req/ack  packed output {im[17:0], re[17:0]}
//   sat_cnt    saturating count of words with any lane clipped
//              (only when CMUL_NARROW_SAT_CNT_EN is defined)
// Optional feature macro: CMUL_NARROW_SAT_CNT_EN

module cmul_narrow #(
    parameter int SHIFT = 17,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [35:0] t0_dat,
    input  logic        t0_req,
    output logic        t0_ack,
    input  logic [35:0] t1_dat,
    input  logic        t1_req,
    output logic        t1_ack,
    output logic [35:0] i2_dat,
    output logic        i2_req,
    input  logic        i2_ack
`ifdef CMUL_NARROW_SAT_CNT_EN
    ,
    output logic [15:0] sat_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic signed [36:0] ROUND   = 37'sd1 <<< (SHIFT - 1);
    localparam logic signed [36:0] SAT_MAX = 37'sd131071;
    localparam logic signed [36:0] SAT_MIN = -37'sd131072;

    logic [1:0][35:0] lane_dat;
    logic [1:0][17:0] sat_val;
    logic [1:0]       sat_hit;

    logic             s1_valid_reg;
    logic [AW:0]      count_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [35:0]      mem [DEPTH];

    logic [AW:0]      occupancy;
    logic             credit;
    logic             accept;
    logic             wr_en;
    logic             rd_en;

    assign lane_dat = {t1_dat, t0_dat};

    // Credit counts every word already committed downstream (stage 1 plus
    // FIFO), so an accepted word always finds a free slot one cycle later.
    // It deliberately ignores i2_ack to keep i2_ack off the t*_ack path.
    assign occupancy = count_reg + {{AW{1'b0}}, s1_valid_reg};
    assign credit    = occupancy < DEPTH_L;

    // reset_n gates the acks so they drop the instant reset is asserted,
    // even while both requests are still high.
    assign accept = reset_n & t0_req & t1_req & credit;
    assign t0_ack = accept;
    assign t1_ack = accept;

    assign wr_en  = s1_valid_reg;
    assign i2_req = (count_reg != '0);
    assign rd_en  = i2_req & i2_ack;

    // Per-lane datapath: round/shift registered on accept, saturate on the
    // way into the FIFO. The add is 37 bits so the rounding bias cannot wrap.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic signed [36:0] rounded;
        logic signed [36:0] s1_reg;
        logic               over_max;
        logic               under_min;

        assign rounded = signed'({lane_dat[gi][35], lane_dat[gi]}) + ROUND;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_reg <= '0;
            end else if (accept) begin
                s1_reg <= rounded >>> SHIFT;
            end
        end

        assign over_max    = s1_reg > SAT_MAX;
        assign under_min   = s1_reg < SAT_MIN;
        assign sat_hit[gi] = over_max | under_min;
        assign sat_val[gi] = over_max  ? 18'h1FFFF :
                             under_min ? 18'h20000 : s1_reg[17:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: i2_dat is forced to zero while the FIFO is
    // empty, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {sat_val[1], sat_val[0]};
        end
    end

    assign i2_dat = i2_req ? mem[rd_ptr_reg] : '0;

`ifdef CMUL_NARROW_SAT_CNT_EN
    logic [15:0] sat_cnt_reg;

    // One count per written word, however many lanes clipped; holds at max.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_cnt_reg <= '0;
        end else if (wr_en && (|sat_hit) && (sat_cnt_reg != 16'hFFFF)) begin
            sat_cnt_reg <= sat_cnt_reg + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_reg;
`else
    logic unused_sat_hit;
    assign unused_sat_hit = ^sat_hit;
`endif

endmodule

// File: tb/tb_cmul_narrow.sv
// Testbench for cmul_narrow: directed steps plus a randomized phase, all
// checked cycle by cycle against a transaction-level reference model.
module tb_cmul_narrow;

    localparam int SHIFT = 17;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [35:0] d0, d1;
    logic        r0, r1;
    logic        t0_ack, t1_ack;
    logic [35:0] i2_dat;
    logic        i2_req;
    logic        i2_ack;
`ifdef CMUL_NARROW_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    cmul_narrow #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset_n(rst_n),
        .t0_dat (d0),
        .t0_req (r0),
        .t0_ack (t0_ack),
        .t1_dat (d1),
        .t1_req (r1),
        .t1_ack (t1_ack),
        .i2_dat (i2_dat),
        .i2_req (i2_req),
        .i2_ack (i2_ack)
`ifdef CMUL_NARROW_SAT_CNT_EN
        ,
        .sat_cnt(sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [35:0] dat;
        int          ready;
    } ent_t;

    ent_t        q[$];          // words accepted and not yet read out
    int          sat_pend[$];   // cycles at which a clipped word becomes counted
    int          sat_exp;
    int          cyc;
    int          checks;
    int          failures;
    bit          fired;
    int          acks_seen;
    logic [35:0] out_log[$];

    // Reference reduction of one lane, straight from the arithmetic rule.
    function automatic logic [17:0] narrow(input logic [35:0] x, output bit sat);
        longint v;
        longint r;
        v = longint'(signed'(x));
        r = (v + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        sat = 1'b0;
        if (r > 131071) begin
            sat = 1'b1;
            return 18'h1FFFF;
        end
        if (r < -131072) begin
            sat = 1'b1;
            return 18'h20000;
        end
        return r[17:0];
    endfunction

    function automatic logic [35:0] rnd36();
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        if (b[31]) return {b[3:0], a};
        return {{4{a[31]}}, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model at
    // the rising edge, return just after it so the caller can drive inputs.
    task automatic step();
        logic        exp_ack;
        logic        exp_req;
        logic        exp_rd;
        logic [35:0] exp_dat;
        bit          s0, s1;
        ent_t        e;
        @(negedge clk);
        while (sat_pend.size() > 0 && sat_pend[0] <= cyc) begin
            void'(sat_pend.pop_front());
            if (sat_exp != 65535) sat_exp++;
        end
        exp_ack = r0 & r1 & (q.size() < DEPTH);
        exp_req = (q.size() > 0) && (q[0].ready <= cyc);
        exp_dat = exp_req ? q[0].dat : 36'd0;
        check("t0_ack", t0_ack, exp_ack);
        check("t1_ack", t1_ack, exp_ack);
        check("i2_req", i2_req, exp_req);
        check("i2_dat", i2_dat, exp_dat);
`ifdef CMUL_NARROW_SAT_CNT_EN
        check("sat_cnt", sat_cnt, sat_exp);
`endif
        if (t0_ack === 1'b1) acks_seen++;
        if (i2_req === 1'b1 && i2_ack === 1'b1) out_log.push_back(i2_dat);
        exp_rd = exp_req & i2_ack;
        fired  = exp_ack;
        @(posedge clk);
        if (exp_rd) void'(q.pop_front());
        if (exp_ack) begin
            e.dat   = {narrow(d1, s1), narrow(d0, s0)};
            e.ready = cyc + 2;
            q.push_back(e);
            if (s0 | s1) sat_pend.push_back(cyc + 2);
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        r0 = 1'b0;
        r1 = 1'b0;
        i2_ack = 1'b1;
        repeat (6) step();
    endtask

    task automatic model_reset();
        q.delete();
        sat_pend.delete();
        sat_exp = 0;
    endtask

    int          k;
    logic [35:0] w;

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        sat_exp = 0;
        fired = 1'b0;
        acks_seen = 0;
        rst_n = 1'b0;
        r0 = 1'b1;
        r1 = 1'b1;
        d0 = 36'd1;
        d1 = 36'd1;
        i2_ack = 1'b1;

        // Reset state, with both requests high
        repeat (2) @(posedge clk);
        #1;
        check("rst_t0_ack", t0_ack, 1'b0);
        check("rst_t1_ack", t1_ack, 1'b0);
        check("rst_i2_req", i2_req, 1'b0);
        check("rst_i2_dat", i2_dat, 36'd0);
`ifdef CMUL_NARROW_SAT_CNT_EN
        check("rst_sat_cnt", sat_cnt, 16'd0);
`endif
        rst_n = 1'b1;

        // Basic: accept on the first edge after release, output 2 cycles later
        d0 = 36'h0_4000_0000;
        d1 = 36'hF_C000_0000;
        step();
        check("basic_fired", fired, 1'b1);
        r0 = 1'b0;
        r1 = 1'b0;
        step();
        check("basic_req", i2_req, 1'b1);
        check("basic_dat", i2_dat, {18'h3E000, 18'h02000});
        step();
        check("basic_req_gone", i2_req, 1'b0);
        drain();

        // Rounding at the half point, back to back
        r0 = 1'b1; r1 = 1'b1;
        d0 = 36'd65536;
        d1 = -36'sd65536;
        step();
        d0 = 36'd65535;
        d1 = -36'sd65537;
        step();
        r0 = 1'b0; r1 = 1'b0;
        check("round_a", i2_dat, {18'h00000, 18'h00001});
        step();
        check("round_b", i2_dat, {18'h3FFFF, 18'h00000});
        drain();

        // Saturation of both lanes, counted once
        r0 = 1'b1; r1 = 1'b1;
        d0 = 36'h7_FFFF_FFFF;
        d1 = 36'h8_0000_0000;
`ifdef CMUL_NARROW_SAT_CNT_EN
        check("sat_cnt_before", sat_cnt, 16'd0);
`endif
        step();
        r0 = 1'b0; r1 = 1'b0;
        step();
        check("sat_dat", i2_dat, {18'h20000, 18'h1FFFF});
`ifdef CMUL_NARROW_SAT_CNT_EN
        check("sat_cnt_after", sat_cnt, 16'd1);
`endif
        drain();

        // Join: one side alone is never acked
        acks_seen = 0;
        r0 = 1'b1;
        d0 = 36'd3 << 17;
        d1 = 36'd5 << 17;
        repeat (3) step();
        check("join_alone_acks", acks_seen, 0);
        r1 = 1'b1;
        step();
        check("join_both_fired", acks_seen, 1);
        r0 = 1'b0; r1 = 1'b0;
        step();
        check("join_out", i2_dat, {18'd5, 18'd3});
        drain();

        // Back-pressure: DEPTH accepted while blocked, then in-order release
        acks_seen = 0;
        out_log.delete();
        i2_ack = 1'b0;
        k = 1;
        r0 = 1'b1; r1 = 1'b1;
        d0 = 36'(k) << 17;
        d1 = 36'(k) << 17;
        for (int i = 0; i < 30; i++) begin
            if (i == 12) begin
                check("bp_accepted", acks_seen, DEPTH);
                i2_ack = 1'b1;
            end
            step();
            if (fired) begin
                k++;
                if (k > 6) begin
                    r0 = 1'b0; r1 = 1'b0;
                end else begin
                    d0 = 36'(k) << 17;
                    d1 = 36'(k) << 17;
                end
            end
        end
        check("bp_count", out_log.size(), 6);
        for (int i = 0; i < out_log.size() && i < 6; i++) begin
            check("bp_order", out_log[i], {18'(i + 1), 18'(i + 1)});
        end
        drain();

        // Randomized traffic honouring the hold-until-acked rule
        for (int i = 0; i < 400; i++) begin
            if (!(r0 && !fired)) begin
                r0 = ($urandom_range(0, 3) != 0);
                d0 = rnd36();
            end
            if (!(r1 && !fired)) begin
                r1 = ($urandom_range(0, 3) != 0);
                d1 = rnd36();
            end
            i2_ack = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset mid-operation with three words in flight
        i2_ack = 1'b0;
        r0 = 1'b1; r1 = 1'b1;
        for (int i = 7; i <= 10; i++) begin
            d0 = 36'(i) << 17;
            d1 = 36'(i) << 17;
            if (i < 10) step();
        end
        check("mid_req_before", i2_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_i2_req", i2_req, 1'b0);
        check("mid_rst_t0_ack", t0_ack, 1'b0);
        check("mid_rst_t1_ack", t1_ack, 1'b0);
        check("mid_rst_i2_dat", i2_dat, 36'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc++;
        i2_ack = 1'b1;
        w = {18'd10, 18'd10};
        step();
        check("mid_first_fired", fired, 1'b1);
        r0 = 1'b0; r1 = 1'b0;
        step();
        check("mid_first_out", i2_dat, w);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmul_narrow.md
# cmul_narrow

Target-side consumer for the complex multiplier's two 36-bit product streams (real and imaginary). It joins the two streams and applies round-half-up, arithmetic right shift and saturation to 18 bits. Results are buffered in a small FIFO and emitted as packed 18-bit I/Q on one req/ack initiator port. It sits directly downstream of the multiplier and returns the datapath to the 18-bit sample format used on its inputs.

## Interface
- SHIFT, 17: right-shift amount applied to each 36-bit product; legal range 1..18.
- DEPTH, 4: output FIFO entries; power of two, at least 2.
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- t0_dat  in  36  real product, signed two's complement.
- t0_req  in  1  real word valid.
- t0_ack  out  1  real word accepted.
- t1_dat  in  36  imaginary product, signed two's complement.
- t1_req  in  1  imaginary word valid.
- t1_ack  out  1  imaginary word accepted.
- i2_dat  out  36  packed output: {im[17:0], re[17:0]}.
- i2_req  out  1  output word valid.
- i2_ack  in  1  downstream accepts the word.
- sat_cnt  out  16  saturation event count; present only with CMUL_NARROW_SAT_CNT_EN.

## Operation
- Handshake rule: a word transfers on any rising edge where req and ack are both high. A req, once raised, is held with stable dat until it is acked.
- Join: t0_ack = t1_ack = t0_req & t1_req & credit. Both inputs are always acked on the same cycle. One input requesting alone is never acked.
- Credit = (fifo_count + stage1_valid) < DEPTH. Credit does not depend on i2_ack in the same cycle, so there is no combinational path from i2_ack to t*_ack.
- Stage 1 (registered on accept): r = (x + (1 << (SHIFT-1))) >>> SHIFT. The add is computed 37 bits wide so it cannot overflow; the shift is arithmetic.
- Stage 2 (into the FIFO): each lane saturates to [-131072, 131071]. Values above the range become 18'h1FFFF; values below become 18'h20000. Re and im saturate independently.
- FIFO: circular buffer of DEPTH entries with wrapping read and write pointers. i2_dat is driven from the head entry and i2_req = (count != 0).
- A write and a read in the same cycle leave the count unchanged; this applies when full and when count is 1.
- A write to a full FIFO cannot occur because of the credit rule.

## Timing
- Latency: with the FIFO empty, a word accepted on the edge that ends cycle N gives i2_req = 1 and valid i2_dat in cycle N+2.
- Throughput: one word per cycle sustained while i2_ack is held high.
- Back-pressure: with i2_ack low, exactly DEPTH words are accepted, after which t*_ack stays low. When i2_ack rises, t*_ack returns to 1 on the next cycle.
- Reset values: t0_ack = 0, t1_ack = 0, i2_req = 0, i2_dat = 0, fifo_count = 0, both pointers = 0, stage1_valid = 0, sat_cnt = 0.
- Reset mid-operation: asserting reset_n low immediately flushes stage 1 and the FIFO and drops all req and ack outputs. After release, the first accept can occur on the first edge at which both inputs request.

## Configuration
- CMUL_NARROW_SAT_CNT_EN defined:
  - sat_cnt port exists.
  - sat_cnt increments by 1 for each word written to the FIFO in which either lane saturated. A word with both lanes saturated counts once.
  - sat_cnt sticks at 16'hFFFF and clears only on reset.
- CMUL_NARROW_SAT_CNT_EN undefined: the port and the counter logic are absent. Saturation behaviour is unchanged.

## Test plan
- Basic: t0_dat = 36'h0_4000_0000, t1_dat = 36'hF_C000_0000, both req at cycle 0, i2_ack = 1 -> both acks high at cycle 0; i2_dat = {18'h3E000, 18'h02000} with i2_req high at cycle 2, held for 1 cycle.
- Rounding at the half point, SHIFT = 17:
  - re = 65536 -> 1; im = -65536 -> 0.
  - re = 65535 -> 0; im = -65537 -> 18'h3FFFF.
- Saturation: re = 36'h7_FFFF_FFFF, im = 36'h8_0000_0000 -> i2_dat = {18'h20000, 18'h1FFFF}; with the macro defined, sat_cnt goes from 0 to 1.
- Join:
  - t0_req high alone for 3 cycles -> t0_ack and t1_ack stay 0.
  - t1_req rising in cycle 3 -> both acks high in cycle 3; one output word results.
- Back-pressure, DEPTH = 4: i2_ack = 0, both inputs streaming values 1..6 << 17 -> exactly 4 words accepted and the rest held. After i2_ack = 1, outputs appear as 1,2,3,4,5,6 in order with no loss or duplication, and the FIFO wrap is exercised.
- Reset mid-operation: 3 words in flight, reset_n low for 1 cycle -> i2_req = 0 and acks = 0 immediately; after release the next output is the first word accepted after reset.
